// File: rtl/tetris_pkg.sv
// Shared types and the tetromino offset table for the board cell pipeline.
// Each table word holds four {dx,dy} nibbles, cell 0 in bits [15:12], row-major top row first.
package tetris_pkg;

    localparam int BOARD_W_DEF = 16;
    localparam int BOARD_H_DEF = 20;

    typedef enum logic [2:0] {
        PC_I    = 3'd0,
        PC_O    = 3'd1,
        PC_T    = 3'd2,
        PC_S    = 3'd3,
        PC_Z    = 3'd4,
        PC_J    = 3'd5,
        PC_L    = 3'd6,
        PC_NONE = 3'd7
    } piece_t;

    typedef struct packed {
        logic [1:0] dx;
        logic [1:0] dy;
    } cell_off_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ERASE  = 2'd1,
        S_DRAW   = 2'd2,
        S_FINISH = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic       do_erase;
        logic       do_draw;
        logic [2:0] old_type;
        logic [1:0] old_rot;
        logic [3:0] old_x;
        logic [4:0] old_y;
        logic [2:0] new_type;
        logic [1:0] new_rot;
        logic [3:0] new_x;
        logic [4:0] new_y;
    } cmd_t;

    // [type][rot]; rotations step clockwise
    localparam logic [15:0] SHAPE_TBL [7][4] = '{
        '{16'h048C, 16'h0123, 16'h048C, 16'h0123},  // I
        '{16'h0415, 16'h0415, 16'h0415, 16'h0415},  // O
        '{16'h0485, 16'h4156, 16'h4159, 16'h0152},  // T
        '{16'h4815, 16'h0156, 16'h4815, 16'h0156},  // S
        '{16'h0459, 16'h4152, 16'h0459, 16'h4152},  // Z
        '{16'h0159, 16'h0412, 16'h0489, 16'h4526},  // J
        '{16'h8159, 16'h0126, 16'h0481, 16'h0456}   // L
    };

endpackage

// File: rtl/tetromino_shape_rom.sv
// Combinational (type, rot, index) -> cell offset lookup; the empty piece type yields (0,0).
module tetromino_shape_rom
    import tetris_pkg::*;
(
    input  logic [2:0] piece,
    input  logic [1:0] rot,
    input  logic [1:0] idx,
    output cell_off_t  off
);

    logic [15:0] row;

    always_comb begin
        row = '0;
        if (piece != PC_NONE) row = SHAPE_TBL[piece][rot];
        case (idx)
            2'd0:    off = cell_off_t'(row[15:12]);
            2'd1:    off = cell_off_t'(row[11:8]);
            2'd2:    off = cell_off_t'(row[7:4]);
            default: off = cell_off_t'(row[3:0]);
        endcase
    end

endmodule

// File: rtl/piece_cell_sequencer.sv
// Expands erase/draw move commands into one board-cell write per cycle for the cell writer,
// with a Start/Busy/Done handshake toward game control.
module piece_cell_sequencer
    import tetris_pkg::*;
#(
    parameter int BOARD_W = BOARD_W_DEF,
    parameter int BOARD_H = BOARD_H_DEF
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Start,
    input  logic       DoErase,
    input  logic       DoDraw,
    input  logic [2:0] OldType,
    input  logic [1:0] OldRot,
    input  logic [3:0] OldX,
    input  logic [4:0] OldY,
    input  logic [2:0] NewType,
    input  logic [1:0] NewRot,
    input  logic [3:0] NewX,
    input  logic [4:0] NewY,
    output logic [3:0] XCOOR,
    output logic [4:0] YCOOR,
    output logic       Enable,
    output logic       Erase,
    output logic       Busy,
    output logic       Done
);

    seq_state_t state_q, state_d;
    logic [1:0] idx_q, idx_d;
    cmd_t       cmd_q, cmd_d, cmd_src;
    logic       accept;

    logic [3:0] xcoor_q, xcoor_d;
    logic [4:0] ycoor_q, ycoor_d;
    logic       enable_q, enable_d;
    logic       erase_q, erase_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [2:0] sel_type;
    logic [1:0] sel_rot;
    logic [3:0] sel_x;
    logic [4:0] sel_y;
    cell_off_t  off;
    logic [4:0] cx;
    logic [5:0] cy;
    logic       in_phase;
    logic       cell_ok;

    // A new command is taken in IDLE and also in the Done cycle, where Busy is already low.
    always_comb begin
        accept  = Start && ((state_q == S_IDLE) || (state_q == S_FINISH));
        cmd_src = '{do_erase: DoErase, do_draw: DoDraw,
                    old_type: OldType, old_rot: OldRot, old_x: OldX, old_y: OldY,
                    new_type: NewType, new_rot: NewRot, new_x: NewX, new_y: NewY};
        cmd_d   = accept ? cmd_src : cmd_q;
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE, S_FINISH: begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
                if (accept) begin
                    if (cmd_src.do_erase)     state_d = S_ERASE;
                    else if (cmd_src.do_draw) state_d = S_DRAW;
                    else                      state_d = S_FINISH;
                end
            end
            S_ERASE: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = cmd_q.do_draw ? S_DRAW : S_FINISH;
            end
            S_DRAW: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = S_FINISH;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    tetromino_shape_rom u_rom (
        .piece (sel_type),
        .rot   (sel_rot),
        .idx   (idx_d),
        .off   (off)
    );

    // Outputs are registered, so the cell is computed from the state being entered.
    always_comb begin
        in_phase = (state_d == S_ERASE) || (state_d == S_DRAW);
        if (state_d == S_ERASE) begin
            sel_type = cmd_d.old_type;
            sel_rot  = cmd_d.old_rot;
            sel_x    = cmd_d.old_x;
            sel_y    = cmd_d.old_y;
        end else begin
            sel_type = cmd_d.new_type;
            sel_rot  = cmd_d.new_rot;
            sel_x    = cmd_d.new_x;
            sel_y    = cmd_d.new_y;
        end
        cx       = {1'b0, sel_x} + {3'b000, off.dx};
        cy       = {1'b0, sel_y} + {4'b0000, off.dy};
        cell_ok  = in_phase && (sel_type != PC_NONE) &&
                   (int'(cx) < BOARD_W) && (int'(cy) < BOARD_H);
        enable_d = cell_ok;
        xcoor_d  = cell_ok ? cx[3:0] : 4'd0;
        ycoor_d  = cell_ok ? cy[4:0] : 5'd0;
        erase_d  = (state_d == S_ERASE);
        busy_d   = in_phase;
        done_d   = (state_d == S_FINISH);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            cmd_q    <= '0;
            xcoor_q  <= 4'd0;
            ycoor_q  <= 5'd0;
            enable_q <= 1'b0;
            erase_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cmd_q    <= cmd_d;
            xcoor_q  <= xcoor_d;
            ycoor_q  <= ycoor_d;
            enable_q <= enable_d;
            erase_q  <= erase_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign XCOOR  = xcoor_q;
    assign YCOOR  = ycoor_q;
    assign Enable = enable_q;
    assign Erase  = erase_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule
